// File: rtl/i2c_target_regport_if.sv
// i2c_target_regport_if: SDA/SCL line levels plus register write/read port of the I2C target.
interface i2c_target_regport_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;
  logic busy;
  logic write_valid;
  logic [15:0] write_addr;
  logic [7:0] write_data;
  logic [15:0] read_addr;
  logic [7:0] read_data;
  modport master (
    output scl_in, sda_in, read_data,
    input  sda_oe, busy, write_valid, write_addr, write_data, read_addr
  );
  modport slave (
    input  scl_in, sda_in, read_data,
    output sda_oe, busy, write_valid, write_addr, write_data, read_addr
  );
endinterface

// File: rtl/i2c_target_regport.sv
// i2c_target_regport: I2C target with a 16-bit register pointer, write strobes and an external read byte source.
module i2c_target_regport #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h24,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic reset,
  i2c_target_regport_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG_HI, HI_ACK, REG_LO, LO_ACK,
    WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d;
  logic [7:0] sr, wd;
  logic [2:0] cnt;
  logic [15:0] ptr, wa;
  logic ack_on, rw, wpend, oe, busy, wv;

  // Idle lines are high, so the synchronizers reset high to avoid phantom edges.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      scl_d <= scl_sync[SYNC_STAGES-1];
      sda_d <= sda_sync[SYNC_STAGES-1];
    end

  logic scl, sda, scl_rise, scl_fall, start, stop, match;
  logic [7:0] shift_in;
  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start = scl & scl_d & sda_d & ~sda;
  assign stop = scl & scl_d & ~sda_d & sda;
  assign shift_in = {sr[6:0], sda};
  assign match = shift_in[7:1] == DEVICE_ADDRESS;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      ptr <= '0;
      ack_on <= 1'b0;
      rw <= 1'b0;
      wpend <= 1'b0;
      oe <= 1'b0;
      busy <= 1'b0;
      wv <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      wv <= 1'b0;
      if (wpend) begin
        wv <= 1'b1;
        wa <= ptr;
        wd <= sr;
        ptr <= ptr + 16'd1;
        wpend <= 1'b0;
      end
      if (start || stop) begin
        state <= start ? ADDR : IDLE;
        cnt <= '0;
        ack_on <= 1'b0;
        oe <= 1'b0;
        busy <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {ADDR, REG_HI, REG_LO, WDATA}) begin
          sr <= shift_in;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7)
            unique case (state)
              ADDR: begin
                busy <= match;
                rw <= shift_in[0];
                state <= match ? ADDR_ACK : IDLE;
              end
              REG_HI: begin
                ptr[15:8] <= shift_in;
                state <= HI_ACK;
              end
              REG_LO: begin
                ptr[7:0] <= shift_in;
                state <= LO_ACK;
              end
              default: begin
                wpend <= 1'b1;
                state <= WDATA_ACK;
              end
            endcase
        end else if (state == RACK) begin
          if (sda) state <= WAIT_STOP;
          else begin
            ptr <= ptr + 16'd1;
            ack_on <= 1'b1;
          end
        end
      end else if (scl_fall) begin
        // ack_on marks the second half of an ACK slot (or a pending reload after a read ACK).
        if (state inside {ADDR_ACK, HI_ACK, LO_ACK, WDATA_ACK}) begin
          oe <= ~ack_on;
          ack_on <= ~ack_on;
          cnt <= '0;
          if (ack_on) state <= state == ADDR_ACK ? REG_HI : state == HI_ACK ? REG_LO : WDATA;
          if (ack_on && state == ADDR_ACK && rw) begin
            sr <= bus.read_data;
            oe <= ~bus.read_data[7];
            cnt <= 3'd1;
            state <= RDATA;
          end
        end else if (state == RDATA) begin
          if (cnt == 3'd0) begin
            oe <= 1'b0;
            state <= RACK;
          end else begin
            oe <= ~sr[~cnt];
            cnt <= cnt + 3'd1;
          end
        end else if (state == RACK && ack_on) begin
          sr <= bus.read_data;
          oe <= ~bus.read_data[7];
          cnt <= 3'd1;
          ack_on <= 1'b0;
          state <= RDATA;
        end
      end
    end

  assign bus.sda_oe = oe;
  assign bus.busy = busy;
  assign bus.write_valid = wv;
  assign bus.write_addr = wa;
  assign bus.write_data = wd;
  assign bus.read_addr = ptr;
endmodule
